// File: rtl/out_port_bank_if.sv
// Bus between the BRISC output-instruction unit (master) and the output
// port bank (slave). Carries the write request and the bank's outputs.
// Optional: OUT_PORT_READBACK_EN adds the registered rd_data readback bus.
interface out_port_bank_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 16,
    parameter int SEL_W     = 4
);
    logic [SEL_W-1:0]            port_sel;
    logic                        out_write_en;
    logic [1:0]                  write_mode;
    logic [DATA_W-1:0]           data_out;
    logic [NUM_PORTS*DATA_W-1:0] ports;
    logic [NUM_PORTS-1:0]        port_strobe;
    logic [NUM_PORTS-1:0]        pulse_busy;
    logic                        sel_err;
`ifdef OUT_PORT_READBACK_EN
    logic [DATA_W-1:0]           rd_data;
`endif

    modport master (
        output port_sel, out_write_en, write_mode, data_out,
`ifdef OUT_PORT_READBACK_EN
        input  rd_data,
`endif
        input  ports, port_strobe, pulse_busy, sel_err
    );

    modport slave (
        input  port_sel, out_write_en, write_mode, data_out,
`ifdef OUT_PORT_READBACK_EN
        output rd_data,
`endif
        output ports, port_strobe, pulse_busy, sel_err
    );
endinterface

// File: rtl/out_port_bank.sv
// Output-port register bank for the BRISC core. NUM_PORTS independent
// DATA_W-bit registers with write / bit-set / bit-clear / timed-pulse modes,
// a one-cycle update strobe per port and an out-of-range select error pulse.
// Optional: define OUT_PORT_READBACK_EN to add the registered rd_data output.
module out_port_bank #(
    parameter int NUM_PORTS    = 4,
    parameter int DATA_W       = 16,
    parameter int SEL_W        = 4,
    parameter int PULSE_CYCLES = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    out_port_bank_if.slave       bus
);
    localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

    localparam logic [1:0] MODE_WRITE = 2'b00;
    localparam logic [1:0] MODE_SET   = 2'b01;
    localparam logic [1:0] MODE_CLEAR = 2'b10;
    localparam logic [1:0] MODE_PULSE = 2'b11;

    logic [NUM_PORTS*DATA_W-1:0] w_ports;
    logic [NUM_PORTS-1:0]        w_strobe;
    logic [NUM_PORTS-1:0]        w_busy;
    logic [NUM_PORTS-1:0]        w_hit;
    logic [DATA_W-1:0]           w_port_arr [NUM_PORTS];
    logic                        w_sel_ok;
    logic                        r_sel_err;

    // Widen by one bit so NUM_PORTS == 2**SEL_W still compares correctly.
    assign w_sel_ok = ({1'b0, bus.port_sel} < (SEL_W + 1)'(NUM_PORTS));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            localparam logic [SEL_W-1:0] K_SEL = SEL_W'(gi);

            logic [DATA_W-1:0] r_port;
            logic [DATA_W-1:0] r_restore;
            logic [CNT_W-1:0]  r_cnt;
            logic              r_busy;
            logic              r_strobe;

            assign w_hit[gi] = bus.out_write_en && (bus.port_sel == K_SEL);

            // Port register, pulse countdown and restore. An accepted write
            // always takes priority over a restore falling on the same edge.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_port    <= '0;
                    r_restore <= '0;
                    r_cnt     <= '0;
                    r_busy    <= 1'b0;
                    r_strobe  <= 1'b0;
                end else begin
                    r_strobe <= 1'b0;
                    if (w_hit[gi]) begin
                        r_strobe <= 1'b1;
                        case (bus.write_mode)
                            MODE_WRITE: begin
                                r_port <= bus.data_out;
                                r_busy <= 1'b0;
                            end
                            MODE_SET: begin
                                r_port <= r_port | bus.data_out;
                                r_busy <= 1'b0;
                            end
                            MODE_CLEAR: begin
                                r_port <= r_port & ~bus.data_out;
                                r_busy <= 1'b0;
                            end
                            default: begin
                                // A retrigger keeps the original pre-pulse value.
                                if (!r_busy) r_restore <= r_port;
                                r_port <= bus.data_out;
                                r_cnt  <= CNT_LOAD;
                                r_busy <= 1'b1;
                            end
                        endcase
                    end else if (r_busy) begin
                        if (r_cnt == '0) begin
                            r_port   <= r_restore;
                            r_busy   <= 1'b0;
                            r_strobe <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
            end

            assign w_ports[gi*DATA_W +: DATA_W] = r_port;
            assign w_port_arr[gi]               = r_port;
            assign w_strobe[gi]                 = r_strobe;
            assign w_busy[gi]                   = r_busy;
        end
    endgenerate

    // Select error pulses for one cycle after an out-of-range write request.
    always_ff @(posedge CLK) begin
        if (RST) r_sel_err <= 1'b0;
        else     r_sel_err <= bus.out_write_en && !w_sel_ok;
    end

    assign bus.ports       = w_ports;
    assign bus.port_strobe = w_strobe;
    assign bus.pulse_busy  = w_busy;
    assign bus.sel_err     = r_sel_err;

`ifdef OUT_PORT_READBACK_EN
    logic [DATA_W-1:0] w_rd_mux;
    logic [DATA_W-1:0] r_rd_data;

    // Select the addressed port; out-of-range selects read as zero.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (bus.port_sel == SEL_W'(i)) w_rd_mux = w_port_arr[i];
        end
    end

    // Registered readback: reflects the port contents one edge later.
    always_ff @(posedge CLK) begin
        if (RST) r_rd_data <= '0;
        else     r_rd_data <= w_rd_mux;
    end

    assign bus.rd_data = r_rd_data;
`else
    logic w_unused_arr;
    assign w_unused_arr = ^{w_port_arr[0], w_sel_ok};
`endif
endmodule

// File: doc/out_port_bank.md
Name: out_port_bank

Overview:
- Parametrised output-port register bank driven by the BRISC core's output instructions.
- Holds NUM_PORTS independently addressable DATA_W-bit output registers.
- Supports four write modes: plain write, bit-set, bit-clear, and timed pulse with auto-restore.
- Emits a one-cycle per-port update strobe so downstream peripherals (LEDs, 7-seg, GPIO) can react to each write.

Parameters:
- NUM_PORTS, 4, number of output ports (1..16).
- DATA_W, 16, width of each port and of data_out.
- SEL_W, 4, width of port_sel; must satisfy 2**SEL_W >= NUM_PORTS.
- PULSE_CYCLES, 8, clock cycles a pulse-mode value is held before restore (>=1).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- port_sel  in  SEL_W  target port index.
- out_write_en  in  1  write request; sampled each rising CLK edge.
- write_mode  in  2  00 write, 01 set, 10 clear, 11 pulse.
- data_out  in  DATA_W  write data or bit mask.
- ports  out  NUM_PORTS*DATA_W  flattened port registers; port k = bits [k*DATA_W +: DATA_W].
- port_strobe  out  NUM_PORTS  one-cycle pulse, bit k high the cycle after port k changes by write or restore.
- pulse_busy  out  NUM_PORTS  bit k high while port k is holding a pulse value.
- sel_err  out  1  one-cycle pulse the cycle after a write with port_sel >= NUM_PORTS.

Behaviour:
- Reset: when RST=1 at a rising edge, all outputs clear to 0 (ports, port_strobe, pulse_busy, sel_err), and all pulse counters and restore registers clear. RST overrides any simultaneous write.
- Write latency: a write accepted at edge N appears on ports after edge N. port_strobe is high for the single cycle following edge N.
- Accepted write: out_write_en=1 and port_sel < NUM_PORTS. Let P be the current value of the selected port.
  - 00 write: P <= data_out.
  - 01 set: P <= P | data_out.
  - 10 clear: P <= P & ~data_out.
  - 11 pulse: P <= data_out; the pre-write P is saved to restore[k]; counter[k] <= PULSE_CYCLES-1; pulse_busy[k] <= 1.
- Pulse countdown (per port, while busy[k]=1): counter[k] decrements each cycle. At the edge where counter[k]=0:
  - P <= restore[k];
  - busy[k] <= 0;
  - port_strobe[k] pulses.
  - The value is therefore held for exactly PULSE_CYCLES cycles.
- Write to a busy port:
  - Mode 00/01/10: applies to the current displayed value and cancels the pulse. busy[k] <= 0; no restore occurs.
  - Mode 11: retriggers. The counter reloads and P <= data_out; restore[k] keeps the original pre-pulse value and is not overwritten.
- Same-edge conflict: if a write to port k coincides with counter[k]=0, the write wins and no restore occurs. A single strobe is produced.
- Independence: writes to other ports never affect port k's counter or restore register; ports may pulse concurrently.
- Out-of-range port_sel: no port changes and no strobe; sel_err pulses one cycle.
- Mode on a write of equal value: port_strobe still fires on every accepted write, even if the value is unchanged.
- out_write_en=0: all registers hold, except pulse countdown/restore.
- Counter width is $clog2(PULSE_CYCLES+1); no wrap-around is possible.

Optional Feature:
- Macro: OUT_PORT_READBACK_EN.
- Defined: adds output rd_data [DATA_W]. Registered with one-cycle latency, it equals the port selected by port_sel at the previous edge, i.e. the post-update value is visible one cycle after any write/restore. It reads 0 for out-of-range port_sel and resets to 0.
- Undefined: the port and its logic are absent; no other behaviour changes.

Test Plan:
1. Reset/plain write: RST 2 cycles, then write mode 00, sel=2, data=16'hBEEF → ports[2]=16'hBEEF next cycle, port_strobe=4'b0100 for one cycle; other ports remain 0.
2. Set/clear: port1=16'h00F0; set with 16'h0F00 → 16'h0FF0; clear with 16'h00F0 → 16'h0F00; each step strobes bit 1.
3. Pulse timing: port0=16'h0001; pulse with 16'hFFFF, PULSE_CYCLES=8 → port0=16'hFFFF and busy[0]=1 for exactly 8 cycles, then 16'h0001 with strobe[0].
4. Pulse interactions:
   - Retrigger at cycle 5 with 16'hAAAA → holds 8 more cycles, then restores 16'h0001.
   - Separate run: mode-00 write 16'h1234 on the restore edge → final 16'h1234, single strobe, busy cleared.
5. Out-of-range and idle: sel=4 write 16'h5555 → sel_err one cycle; no ports change; no strobe. out_write_en=0 with random data/sel for 20 cycles → no change.
6. Reset mid-pulse: RST asserted at pulse cycle 3 → all ports 0, busy=0, and no later restore occurs. With OUT_PORT_READBACK_EN: sel=2 after scenario 1 → rd_data=16'hBEEF one cycle later.
